// File: rtl/fire_layer_sequencer_if.sv
// Handshake bundle between the expand3 sequencer, the layer datapath and the feature-map RAMs.
interface fire_layer_sequencer_if #(
  parameter int WOUT = 16,
  parameter int CHIN = 64
);
  localparam int IA_W = $clog2(WOUT * WOUT * CHIN);
  localparam int OA_W = $clog2(WOUT * WOUT);

  logic            start_i;
  logic            hold_i;
  logic            layer_sample_i;
  logic            layer_finish_i;
  logic            layer_en_o;
  logic [IA_W-1:0] ifm_addr_o;
  logic            ifm_pad_o;
  logic            ofm_wr_o;
  logic [OA_W-1:0] ofm_addr_o;
  logic            ram_feedback_o;
  logic            busy_o;
  logic            done_o;

  modport slave (
    input  start_i, hold_i, layer_sample_i, layer_finish_i,
    output layer_en_o, ifm_addr_o, ifm_pad_o, ofm_wr_o, ofm_addr_o,
           ram_feedback_o, busy_o, done_o
  );

  modport master (
    output start_i, hold_i, layer_sample_i, layer_finish_i,
    input  layer_en_o, ifm_addr_o, ifm_pad_o, ofm_wr_o, ofm_addr_o,
           ram_feedback_o, busy_o, done_o
  );
endinterface

// File: rtl/fire_layer_sequencer.sv
// Raster-order tap sequencer for a 3x3/stride-1/pad-1 expand layer: issues IFM reads with
// border padding plus one flush slot per pixel, and turns layer samples into OFM writes.
module fire_layer_sequencer #(
  parameter int WOUT       = 16,
  parameter int CHIN       = 64,
  parameter int KERNEL_DIM = 3
) (
  input logic                   clk,
  input logic                   rst,
  fire_layer_sequencer_if.slave bus
);
  localparam int unsigned PAD  = (KERNEL_DIM - 1) / 2;
  localparam int          NPIX = WOUT * WOUT;
  localparam int          IA_W = $clog2(NPIX * CHIN);
  localparam int          OA_W = $clog2(NPIX);
  localparam int          RW   = (WOUT > 1) ? $clog2(WOUT) : 1;
  localparam int          KW   = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
  localparam int          CW   = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int          SW   = OA_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FEEDBACK, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_row, r_col, w_row_nxt, w_col_nxt;
  logic [KW-1:0]   r_ky, r_kx, w_ky_nxt, w_kx_nxt;
  logic [CW-1:0]   r_ch, w_ch_nxt;
  logic            r_flush, w_flush_nxt;
  logic [SW-1:0]   r_samples;
  logic            r_en, r_pad, r_wr;
  logic [IA_W-1:0] r_addr;
  logic [OA_W-1:0] r_ofm_addr;
  logic            w_start, w_issue, w_sample, w_last_pixel;

  // Borders are found from unsigned sums r+ky / c+kx against the padded window.
  function automatic logic tap_pad(input logic [RW-1:0] row, input logic [RW-1:0] col,
                                   input logic [KW-1:0] ky, input logic [KW-1:0] kx,
                                   input logic flush);
    int unsigned yy, xx;
    yy = 32'(row) + 32'(ky);
    xx = 32'(col) + 32'(kx);
    return flush || (yy < PAD) || (yy >= WOUT + PAD) || (xx < PAD) || (xx >= WOUT + PAD);
  endfunction

  function automatic logic [IA_W-1:0] tap_addr(input logic [RW-1:0] row, input logic [RW-1:0] col,
                                               input logic [KW-1:0] ky, input logic [KW-1:0] kx,
                                               input logic [CW-1:0] ch, input logic flush);
    int unsigned yy, xx;
    if (tap_pad(row, col, ky, kx, flush)) return '0;
    yy = 32'(row) + 32'(ky) - PAD;
    xx = 32'(col) + 32'(kx) - PAD;
    return IA_W'((yy * WOUT + xx) * CHIN + 32'(ch));
  endfunction

  assign w_start      = bus.start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_issue      = (r_state == S_RUN) && !bus.hold_i;
  assign w_last_pixel = r_flush && (r_row == RW'(WOUT - 1)) && (r_col == RW'(WOUT - 1));
  assign w_sample     = bus.layer_sample_i && (r_samples != SW'(NPIX)) &&
                        (r_state == S_RUN || r_state == S_DRAIN || r_state == S_FEEDBACK);

  // Tap walk: ch innermost, then kx, then ky, then the flush slot, then the next pixel.
  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_ky_nxt    = r_ky;
    w_kx_nxt    = r_kx;
    w_ch_nxt    = r_ch;
    w_flush_nxt = r_flush;
    if (w_start) begin
      w_row_nxt   = '0;
      w_col_nxt   = '0;
      w_ky_nxt    = '0;
      w_kx_nxt    = '0;
      w_ch_nxt    = '0;
      w_flush_nxt = 1'b0;
    end else if (w_issue) begin
      if (r_flush) begin
        w_flush_nxt = 1'b0;
        if (r_col == RW'(WOUT - 1)) begin
          w_col_nxt = '0;
          w_row_nxt = (r_row == RW'(WOUT - 1)) ? '0 : r_row + RW'(1);
        end else begin
          w_col_nxt = r_col + RW'(1);
        end
      end else if (r_ch != CW'(CHIN - 1)) begin
        w_ch_nxt = r_ch + CW'(1);
      end else begin
        w_ch_nxt = '0;
        if (r_kx != KW'(KERNEL_DIM - 1)) begin
          w_kx_nxt = r_kx + KW'(1);
        end else begin
          w_kx_nxt = '0;
          if (r_ky != KW'(KERNEL_DIM - 1)) begin
            w_ky_nxt = r_ky + KW'(1);
          end else begin
            w_ky_nxt    = '0;
            w_flush_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (bus.start_i) w_state_nxt = S_RUN;
      S_RUN:          if (w_issue && w_last_pixel) w_state_nxt = S_DRAIN;
      S_DRAIN:        if (r_samples == SW'(NPIX) && bus.layer_finish_i) w_state_nxt = S_FEEDBACK;
      S_FEEDBACK:     w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_ch       <= '0;
      r_flush    <= 1'b0;
      r_samples  <= '0;
      r_en       <= 1'b0;
      r_pad      <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_ofm_addr <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_ky    <= w_ky_nxt;
      r_kx    <= w_kx_nxt;
      r_ch    <= w_ch_nxt;
      r_flush <= w_flush_nxt;
      // Address leads enable/pad by one cycle to match the RAM read latency.
      r_addr  <= tap_addr(w_row_nxt, w_col_nxt, w_ky_nxt, w_kx_nxt, w_ch_nxt, w_flush_nxt);
      r_en    <= w_issue;
      r_pad   <= w_issue && tap_pad(r_row, r_col, r_ky, r_kx, r_flush);
      r_wr    <= w_sample;
      if (w_sample) r_ofm_addr <= r_samples[OA_W-1:0];
      if (w_start)       r_samples <= '0;
      else if (w_sample) r_samples <= r_samples + SW'(1);
    end
  end

  assign bus.layer_en_o     = r_en;
  assign bus.ifm_addr_o     = r_addr;
  assign bus.ifm_pad_o      = r_pad;
  assign bus.ofm_wr_o       = r_wr;
  assign bus.ofm_addr_o     = r_ofm_addr;
  assign bus.ram_feedback_o = (r_state == S_FEEDBACK);
  assign bus.busy_o         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done_o         = (r_state == S_DONE);
endmodule
